// File: rtl/layer_seq_pkg.sv
// Shared definitions for the layer output sequencer: FSM states and index-width helper.
package layer_seq_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } seq_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running signed maximum over accepted beats; reports the winning index one cycle
// after the last beat of a layer is accepted. Lowest index wins ties.
module argmax_tracker
  import layer_seq_pkg::*;
#(
  parameter int NN        = 30,
  parameter int dataWidth = 16,
  parameter int IDX_W     = idx_w(NN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        beat_acc_i,
  input  logic                        beat_last_i,
  input  logic        [IDX_W-1:0]     beat_idx_i,
  input  logic signed [dataWidth-1:0] beat_data_i,
  output logic        [IDX_W-1:0]     max_idx_o,
  output logic                        max_valid_o
);

  logic signed [dataWidth-1:0] run_max_q;
  logic        [IDX_W-1:0]     run_idx_q;
  logic        [IDX_W-1:0]     max_idx_q;
  logic                        max_valid_q;
  logic                        take;
  logic signed [dataWidth-1:0] cand_max;
  logic        [IDX_W-1:0]     cand_idx;

  // Strict greater-than keeps the earlier index on equal values.
  always_comb begin
    take     = (beat_idx_i == '0) || (beat_data_i > run_max_q);
    cand_max = take ? beat_data_i : run_max_q;
    cand_idx = take ? beat_idx_i  : run_idx_q;
  end

  always_ff @(posedge clk) begin
    if (beat_acc_i) begin
      run_max_q <= cand_max;
      run_idx_q <= cand_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_idx_q   <= '0;
      max_valid_q <= 1'b0;
    end else begin
      max_valid_q <= beat_acc_i && beat_last_i;
      if (beat_acc_i && beat_last_i) max_idx_q <= cand_idx;
    end
  end

  assign max_idx_o   = max_idx_q;
  assign max_valid_o = max_valid_q;

endmodule

// File: rtl/layer_sequencer.sv
// Captures a full layer result and streams it one neuron per beat with valid/ready.
// Optional argmax tracking is enabled by defining LAYER_SEQ_ARGMAX_EN.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter  int NN        = 30,
  parameter  int dataWidth = 16,
  localparam int IDX_W     = idx_w(NN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NN-1:0]               i_valid,
  input  logic [NN*dataWidth-1:0]     i_data,
  input  logic                        o_ready,
  output logic                        o_valid,
  output logic signed [dataWidth-1:0] o_data,
  output logic [IDX_W-1:0]            o_idx,
  output logic                        o_last,
  output logic                        busy,
  output logic                        overflow,
  input  logic                        clr_overflow
`ifdef LAYER_SEQ_ARGMAX_EN
  ,
  output logic [IDX_W-1:0]            max_idx,
  output logic                        max_valid
`endif
);

  seq_state_e                  state_q, state_d;
  logic        [IDX_W-1:0]     idx_q, idx_d;
  logic                        overflow_q, overflow_d;
  logic signed [dataWidth-1:0] buf_q [NN];

  logic all_valid, accept, accept_last, capture, ovf_set;

  always_comb begin
    all_valid   = &i_valid;
    accept      = (state_q == STREAM) && o_ready;
    accept_last = accept && (idx_q == IDX_W'(NN - 1));
    capture     = all_valid && ((state_q == IDLE) || accept_last);
    ovf_set     = all_valid && (state_q == STREAM) && !accept_last;

    state_d    = state_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;

    if (state_q == IDLE) begin
      if (capture) begin
        state_d = STREAM;
        idx_d   = '0;
      end
    end else begin
      if (accept_last) begin
        idx_d = '0;
        // A result arriving with the final accepted beat chains straight on.
        if (!capture) state_d = IDLE;
      end else if (accept) begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if (ovf_set)           overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < NN; k++) buf_q[k] <= i_data[k*dataWidth +: dataWidth];
    end
  end

  // Outputs are gated by state so reset drives them to zero immediately.
  assign o_valid  = (state_q == STREAM);
  assign o_data   = o_valid ? buf_q[idx_q] : '0;
  assign o_idx    = o_valid ? idx_q : '0;
  assign o_last   = o_valid && (idx_q == IDX_W'(NN - 1));
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

`ifdef LAYER_SEQ_ARGMAX_EN
  argmax_tracker #(
    .NN        (NN),
    .dataWidth (dataWidth),
    .IDX_W     (IDX_W)
  ) u_argmax (
    .clk         (clk),
    .rst         (rst),
    .beat_acc_i  (accept),
    .beat_last_i (o_last),
    .beat_idx_i  (o_idx),
    .beat_data_i (o_data),
    .max_idx_o   (max_idx),
    .max_valid_o (max_valid)
  );
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer at NN=4: directed scenarios plus randomized traffic vs a reference model.
module tb_layer_sequencer;

  localparam int NN = 4;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NN-1:0]        i_valid;
  logic [NN*DW-1:0]     i_data;
  logic                 o_ready;
  logic                 o_valid;
  logic signed [DW-1:0] o_data;
  logic [1:0]           o_idx;
  logic                 o_last;
  logic                 busy;
  logic                 overflow;
  logic                 clr_overflow;
`ifdef LAYER_SEQ_ARGMAX_EN
  logic [1:0]           max_idx;
  logic                 max_valid;
`endif

  int checks = 0;
  int errors = 0;

  layer_sequencer #(.NN(NN), .dataWidth(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_idx        (o_idx),
    .o_last       (o_last),
    .busy         (busy),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef LAYER_SEQ_ARGMAX_EN
    ,
    .max_idx      (max_idx),
    .max_valid    (max_valid)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [NN*DW-1:0] pack(input int w0, input int w1, input int w2, input int w3);
    logic [NN*DW-1:0] v;
    v[0*DW +: DW] = DW'(w0);
    v[1*DW +: DW] = DW'(w1);
    v[2*DW +: DW] = DW'(w2);
    v[3*DW +: DW] = DW'(w3);
    return v;
  endfunction

  // Apply inputs at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic tick(input logic [NN-1:0] v, input logic [NN*DW-1:0] d, input logic rdy, input logic clr);
    i_valid      = v;
    i_data       = d;
    o_ready      = rdy;
    clr_overflow = clr;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    i_valid = '1; i_data = pack(1, 2, 3, 4); o_ready = 1'b1; clr_overflow = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %0b want 0", o_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    checks++; if (o_data !== 16'sd0 || o_idx !== 2'd0 || o_last !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got data=%0d idx=%0d last=%0b want 0/0/0", o_data, o_idx, o_last);
    end
`ifdef LAYER_SEQ_ARGMAX_EN
    checks++; if (max_valid !== 1'b0 || max_idx !== 2'd0) begin
      errors++; $display("FAIL reset_argmax got valid=%0b idx=%0d want 0/0", max_valid, max_idx);
    end
`endif
    i_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream;
    int exp_d[4] = '{12, 7, -3, 40};
    tick(4'hF, pack(12, 7, -3, 40), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== DW'(exp_d[i]) || o_idx !== 2'(i) || o_last !== (i == 3)) begin
        errors++;
        $display("FAIL stream_beat%0d got v=%0b d=%0d idx=%0d last=%0b want 1/%0d/%0d/%0b",
                 i, o_valid, o_data, o_idx, o_last, exp_d[i], i, (i == 3));
      end
      tick('0, '0, 1'b1, 1'b0);
    end
    checks++; if (busy !== 1'b0 || o_valid !== 1'b0) begin
      errors++; $display("FAIL stream_done got busy=%0b valid=%0b want 0/0", busy, o_valid);
    end
  endtask

  task automatic test_backpressure;
    tick(4'hF, pack(12, 7, -3, 40), 1'b1, 1'b0);
    tick('0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick('0, '0, 1'b0, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 16'sd7 || o_idx !== 2'd1) begin
        errors++; $display("FAIL stall%0d got v=%0b d=%0d idx=%0d want 1/7/1", i, o_valid, o_data, o_idx);
      end
    end
    tick('0, '0, 1'b1, 1'b0);
    checks++; if (o_data !== -16'sd3 || o_idx !== 2'd2) begin
      errors++; $display("FAIL stall_resume got d=%0d idx=%0d want -3/2", o_data, o_idx);
    end
    tick('0, '0, 1'b1, 1'b0);
    checks++; if (o_data !== 16'sd40 || o_last !== 1'b1) begin
      errors++; $display("FAIL stall_last got d=%0d last=%0b want 40/1", o_data, o_last);
    end
    tick('0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow;
    tick(4'b0111, pack(9, 9, 9, 9), 1'b1, 1'b0);
    checks++; if (busy !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL partial_ignored got busy=%0b ovf=%0b want 0/0", busy, overflow);
    end
    tick(4'hF, pack(12, 7, -3, 40), 1'b1, 1'b0);
    tick('0, '0, 1'b1, 1'b0);
    tick('0, '0, 1'b1, 1'b0);
    tick(4'hF, pack(1, 2, 3, 4), 1'b1, 1'b0);
    checks++; if (overflow !== 1'b1 || o_data !== 16'sd40 || o_idx !== 2'd3) begin
      errors++; $display("FAIL ovf_set got ovf=%0b d=%0d idx=%0d want 1/40/3", overflow, o_data, o_idx);
    end
    tick('0, '0, 1'b1, 1'b0);
    checks++; if (overflow !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL ovf_sticky got ovf=%0b busy=%0b want 1/0", overflow, busy);
    end
    tick('0, '0, 1'b1, 1'b1);
    checks++; if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got %0b want 0", overflow);
    end
    // Set wins over a simultaneous clear.
    tick(4'hF, pack(5, 6, 7, 8), 1'b0, 1'b0);
    tick(4'hF, pack(5, 6, 7, 8), 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1 || o_data !== 16'sd5) begin
      errors++; $display("FAIL ovf_priority got ovf=%0b d=%0d want 1/5", overflow, o_data);
    end
    repeat (4) tick('0, '0, 1'b1, 1'b0);
    tick('0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back;
    int exp_d[4] = '{-100, 200, 0, 32767};
    tick(4'hF, pack(12, 7, -3, 40), 1'b1, 1'b0);
    repeat (3) tick('0, '0, 1'b1, 1'b0);
    tick(4'hF, pack(-100, 200, 0, 32767), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== DW'(exp_d[i]) || o_idx !== 2'(i) || overflow !== 1'b0) begin
        errors++;
        $display("FAIL b2b_beat%0d got v=%0b d=%0d idx=%0d ovf=%0b want 1/%0d/%0d/0",
                 i, o_valid, o_data, o_idx, overflow, exp_d[i], i);
      end
      tick('0, '0, 1'b1, 1'b0);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done got busy=%0b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    tick(4'hF, pack(12, 7, -3, 40), 1'b1, 1'b0);
    tick('0, '0, 1'b1, 1'b0);
    tick('0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid got valid=%0b busy=%0b want 0/0", o_valid, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick('0, '0, 1'b1, 1'b0);
      checks++; if (o_valid !== 1'b0) begin
        errors++; $display("FAIL rst_after%0d got valid=%0b want 0", i, o_valid);
      end
    end
  endtask

`ifdef LAYER_SEQ_ARGMAX_EN
  task automatic test_argmax;
    tick(4'hF, pack(12, 40, 40, -3), 1'b1, 1'b0);
    repeat (4) tick('0, '0, 1'b1, 1'b0);
    checks++; if (max_valid !== 1'b1 || max_idx !== 2'd1) begin
      errors++; $display("FAIL argmax_pulse got valid=%0b idx=%0d want 1/1", max_valid, max_idx);
    end
    tick('0, '0, 1'b1, 1'b0);
    checks++; if (max_valid !== 1'b0 || max_idx !== 2'd1) begin
      errors++; $display("FAIL argmax_hold got valid=%0b idx=%0d want 0/1", max_valid, max_idx);
    end
  endtask
`endif

  // Model: a layer is either being delivered (with a read position) or not.
  task automatic test_random;
    logic                 m_act;
    int                   m_pos;
    logic signed [DW-1:0] m_buf [NN];
    logic                 m_ovf;
    logic [NN-1:0]        v;
    logic [NN*DW-1:0]     d;
    logic                 rdy, clr, allv, took_last;
    int                   r;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_act = 1'b0; m_pos = 0; m_ovf = 1'b0;
    for (int k = 0; k < NN; k++) m_buf[k] = '0;
    for (int n = 0; n < 400; n++) begin
      checks++;
      if (o_valid !== m_act || busy !== m_act || overflow !== m_ovf) begin
        errors++; $display("FAIL rnd_ctrl@%0d got v=%0b busy=%0b ovf=%0b want %0b/%0b/%0b",
                           n, o_valid, busy, overflow, m_act, m_act, m_ovf);
      end
      if (m_act) begin
        checks++;
        if (o_data !== m_buf[m_pos] || o_idx !== 2'(m_pos) || o_last !== (m_pos == NN - 1)) begin
          errors++; $display("FAIL rnd_beat@%0d got d=%0d idx=%0d last=%0b want %0d/%0d/%0b",
                             n, o_data, o_idx, o_last, m_buf[m_pos], m_pos, (m_pos == NN - 1));
        end
      end
      r = $urandom_range(0, 9);
      if (r < 3)      v = '1;
      else if (r < 5) v = NN'($urandom_range(1, 14));
      else            v = '0;
      d   = {$urandom, $urandom};
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      allv = (v == '1);
      took_last = m_act && rdy && (m_pos == NN - 1);
      if (m_act && allv && !took_last) m_ovf = 1'b1;
      else if (clr)                    m_ovf = 1'b0;
      if (m_act && rdy) begin
        if (m_pos == NN - 1) m_act = 1'b0;
        else                 m_pos = m_pos + 1;
      end
      if (allv && !m_act) begin
        for (int k = 0; k < NN; k++) m_buf[k] = d[k*DW +: DW];
        m_act = 1'b1;
        m_pos = 0;
      end
      tick(v, d, rdy, clr);
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
`ifdef LAYER_SEQ_ARGMAX_EN
    test_argmax;
`endif
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter NN, default 30, number of neurons in the producing layer.
REQ-002 SHALL have parameter dataWidth, default 16, width of one neuron output word (signed two's complement).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_valid  input  NN  per-neuron outvalid from the layer.
REQ-006 SHALL have port i_data  input  NN*dataWidth  layer outputs; neuron k at bits [k*dataWidth +: dataWidth].
REQ-007 SHALL have port o_ready  input  1  downstream accepts current beat.
REQ-008 SHALL have port o_valid  output  1  beat valid toward next layer x_valid.
REQ-009 SHALL have port o_data  output  dataWidth  beat data toward next layer x_in.
REQ-010 SHALL have port o_idx  output  IDX_W  neuron index of current beat; IDX_W = max(1, clog2(NN)).
REQ-011 SHALL have port o_last  output  1  high on beat with o_idx == NN-1.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port overflow  output  1  sticky: layer result dropped.
REQ-014 SHALL have port clr_overflow  input  1  synchronous clear of overflow.

Function
REQ-015 SHALL implement states IDLE and STREAM.
REQ-016 SHALL capture all of i_data into an NN-word buffer in the cycle &i_valid is high and state is IDLE, then enter STREAM with index 0.
REQ-017 SHALL ignore cycles where i_valid is partially set (neither all ones nor zero); no capture, no flag.
REQ-018 SHALL in STREAM drive o_valid=1, o_data=buffer[idx], o_idx=idx; first beat appears the cycle after capture (latency 1).
REQ-019 SHALL advance idx only on o_valid && o_ready; o_data/o_idx SHALL hold stable while o_ready is low.
REQ-020 SHALL on acceptance of the o_last beat return to IDLE, unless &i_valid is high that same cycle, in which case it SHALL capture the new result and remain in STREAM with idx 0 (back-to-back, no bubble).
REQ-021 SHALL set overflow when &i_valid is high in STREAM and REQ-020 does not apply; buffer contents SHALL be unaffected.
REQ-022 SHALL give set priority over clr_overflow when both occur in one cycle.
REQ-023 SHALL never write the buffer during STREAM except via REQ-020.

Reset
REQ-024 SHALL, while rst is low, force state IDLE, idx 0, o_valid 0, o_last 0, o_idx 0, o_data 0, busy 0, overflow 0, and all argmax outputs 0.
REQ-025 SHALL, on reset mid-STREAM, abandon the stream; the first beat after release requires a fresh capture.

Configuration
REQ-026 SHALL, when macro LAYER_SEQ_ARGMAX_EN is defined, add outputs max_idx (IDX_W) and max_valid (1): running signed maximum over accepted beats, lowest index wins ties, max_valid pulses one cycle after the o_last beat is accepted with max_idx held until the next pulse.
REQ-027 SHALL, without LAYER_SEQ_ARGMAX_EN, omit max_idx/max_valid ports and all comparator logic.

Structure
REQ-028 SHALL place the state enum (IDLE, STREAM) and the IDX_W helper function in shared package layer_seq_pkg.
REQ-029 SHALL implement argmax logic in sub-module argmax_tracker, instantiated only under LAYER_SEQ_ARGMAX_EN.

Verification
REQ-030 SHALL cover: NN=4, i_data={40,-3,7,12} words 3..0, all valid, o_ready=1 -> beats 12,7,-3,40 on idx 0..3 in four consecutive cycles, o_last on idx 3, busy falls after.
REQ-031 SHALL cover: o_ready low 3 cycles at idx 1 -> o_data stays 7, o_idx stays 1, no beat lost.
REQ-032 SHALL cover: second &i_valid during idx 2 -> overflow=1, stream completes with original data; clr_overflow -> overflow=0 next cycle.
REQ-033 SHALL cover: &i_valid coincident with accepted o_last -> next cycle o_valid=1, idx 0, new data, overflow stays 0.
REQ-034 SHALL cover: rst low at idx 2 -> o_valid=0, busy=0 immediately; no beats until next capture.
REQ-035 SHALL cover (LAYER_SEQ_ARGMAX_EN): data {12,40,40,-3} -> max_valid pulse with max_idx=1.
